// File: rtl/id_regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : id_regfile_ctrl_pkg
//  Brief   : Shared types and constants for the ID-stage regfile controller.
//  Revision: 1.0
// ============================================================================
package id_regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        RUN       = 2'd1,
        HALT_WAIT = 2'd2,
        HALTED    = 2'd3
    } rf_ctrl_state_t;

    localparam int unsigned X0_ADDR = 0;

endpackage
`default_nettype wire

// File: rtl/id_regfile_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : id_regfile_ctrl_if
//  Brief   : WB / debug / regfile signal bundle around the regfile controller.
//  Revision: 1.0
// ============================================================================
interface id_regfile_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  WB_wr_en;
    logic [ADDR_WIDTH-1:0] WB_rd_address;
    logic [DATA_WIDTH-1:0] WB_rd_data;
    logic [ADDR_WIDTH-1:0] ID_rs1_address;
    logic [DATA_WIDTH-1:0] Rf_rs1_data;
    logic                  Pipe_empty;
    logic                  Dbg_halt_req;
    logic                  Dbg_req_valid;
    logic                  Dbg_req_write;
    logic [ADDR_WIDTH-1:0] Dbg_req_address;
    logic [DATA_WIDTH-1:0] Dbg_req_wdata;
    logic                  Dbg_req_ready;
    logic                  Dbg_rsp_valid;
    logic [DATA_WIDTH-1:0] Dbg_rsp_rdata;
    logic                  Rf_wr_en;
    logic [ADDR_WIDTH-1:0] Rf_rd_address;
    logic [DATA_WIDTH-1:0] Rf_wr_data;
    logic [ADDR_WIDTH-1:0] Rf_rs1_address;
    logic                  Stall_req;
    logic                  Halted;
    logic                  Init_done;

    // Environment side: pipeline, debug unit and regfile together
    modport master (
        output WB_wr_en, WB_rd_address, WB_rd_data, ID_rs1_address, Rf_rs1_data,
               Pipe_empty, Dbg_halt_req, Dbg_req_valid, Dbg_req_write,
               Dbg_req_address, Dbg_req_wdata,
        input  Dbg_req_ready, Dbg_rsp_valid, Dbg_rsp_rdata, Rf_wr_en, Rf_rd_address,
               Rf_wr_data, Rf_rs1_address, Stall_req, Halted, Init_done
    );

    modport slave (
        input  WB_wr_en, WB_rd_address, WB_rd_data, ID_rs1_address, Rf_rs1_data,
               Pipe_empty, Dbg_halt_req, Dbg_req_valid, Dbg_req_write,
               Dbg_req_address, Dbg_req_wdata,
        output Dbg_req_ready, Dbg_rsp_valid, Dbg_rsp_rdata, Rf_wr_en, Rf_rd_address,
               Rf_wr_data, Rf_rs1_address, Stall_req, Halted, Init_done
    );
endinterface
`default_nettype wire

// File: rtl/id_regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : id_regfile_ctrl
//  Brief   : Regfile clear sequencer, write-port arbiter and debug halt access.
//  Revision: 1.0
// ============================================================================
module id_regfile_ctrl
    import id_regfile_ctrl_pkg::*;
#(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32
) (
    input  wire              Clk_100MHz,
    input  wire              Reset,
    id_regfile_ctrl_if.slave bus
);
    localparam int CW = $clog2(REGFILE_DEPTH) + 1;
    localparam logic [CW-1:0]                 c_LAST_CLR = CW'(REGFILE_DEPTH - 1);
    localparam logic [REGFILE_ADDR_WIDTH-1:0] c_X0       = REGFILE_ADDR_WIDTH'(X0_ADDR);

    rf_ctrl_state_t              state_q;
    logic [CW-1:0]               clr_cnt_q;
    logic                        stall_q;
    logic                        halted_q;
    logic                        init_done_q;
    logic                        rsp_valid_q;
    logic [REG_DATA_WIDTH-1:0]   rsp_rdata_q;

    logic                          w_ready;
    logic                          w_accept;
    logic                          w_wr_en;
    logic [REGFILE_ADDR_WIDTH-1:0] w_wr_addr;
    logic [REG_DATA_WIDTH-1:0]     w_wr_data;
    logic [REGFILE_ADDR_WIDTH-1:0] w_rs1_addr;

    // WB owns the port whenever it writes, so debug only gets in on idle WB cycles
    assign w_ready  = (state_q == HALTED) && !bus.WB_wr_en;
    assign w_accept = bus.Dbg_req_valid && w_ready;

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_addr  = bus.WB_rd_address;
        w_wr_data  = bus.WB_rd_data;
        w_rs1_addr = bus.ID_rs1_address;
        case (state_q)
            INIT: begin
                w_wr_en    = 1'b1;
                w_wr_addr  = clr_cnt_q[REGFILE_ADDR_WIDTH-1:0];
                w_wr_data  = '0;
                w_rs1_addr = '0;
            end
            RUN, HALT_WAIT: begin
                w_wr_en = bus.WB_wr_en;
            end
            HALTED: begin
                if (bus.WB_wr_en) begin
                    w_wr_en = 1'b1;
                end else if (w_accept && bus.Dbg_req_write) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = bus.Dbg_req_address;
                    w_wr_data = bus.Dbg_req_wdata;
                end
                if (w_accept && !bus.Dbg_req_write) begin
                    w_rs1_addr = bus.Dbg_req_address;
                end
            end
            default: w_wr_en = 1'b0;
        endcase
        if (state_q != INIT && w_wr_addr == c_X0) begin
            w_wr_en = 1'b0;
        end
    end

    always_ff @(posedge Clk_100MHz or posedge Reset) begin
        if (Reset) begin
            state_q     <= INIT;
            clr_cnt_q   <= '0;
            stall_q     <= 1'b1;
            halted_q    <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= w_accept;
            if (w_accept) begin
                rsp_rdata_q <= (!bus.Dbg_req_write && bus.Dbg_req_address != c_X0)
                             ? bus.Rf_rs1_data : '0;
            end
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == c_LAST_CLR) begin
                        state_q     <= RUN;
                        stall_q     <= 1'b0;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.Dbg_halt_req) begin
                        state_q <= HALT_WAIT;
                        stall_q <= 1'b1;
                    end
                end
                HALT_WAIT: begin
                    if (!bus.Dbg_halt_req) begin
                        state_q <= RUN;
                        stall_q <= 1'b0;
                    end else if (bus.Pipe_empty) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!bus.Dbg_halt_req) begin
                        state_q  <= RUN;
                        stall_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.Dbg_req_ready  = w_ready;
    assign bus.Dbg_rsp_valid  = rsp_valid_q;
    assign bus.Dbg_rsp_rdata  = rsp_rdata_q;
    assign bus.Rf_wr_en       = w_wr_en && !Reset;
    assign bus.Rf_rd_address  = w_wr_addr;
    assign bus.Rf_wr_data     = w_wr_data;
    assign bus.Rf_rs1_address = w_rs1_addr;
    assign bus.Stall_req      = stall_q;
    assign bus.Halted         = halted_q;
    assign bus.Init_done      = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_id_regfile_ctrl
//  Brief   : Directed self-checking bench for id_regfile_ctrl with a small regfile model.
//  Revision: 1.0
// ============================================================================
module tb_id_regfile_ctrl;
    logic Clk_100MHz = 1'b0;
    logic Reset      = 1'b1;
    logic poison_x0  = 1'b0;
    int   errors     = 0;
    int   checks     = 0;
    logic [31:0] mem [0:31];

    always #5 Clk_100MHz = ~Clk_100MHz;

    id_regfile_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    id_regfile_ctrl #(
        .REG_DATA_WIDTH(32), .REGFILE_ADDR_WIDTH(5), .REGFILE_DEPTH(32)
    ) dut (
        .Clk_100MHz(Clk_100MHz),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    // Regfile model; poison_x0 makes a raw x0 read nonzero so zeroing is observable
    always @(posedge Clk_100MHz) if (bus.Rf_wr_en) mem[bus.Rf_rd_address] <= bus.Rf_wr_data;
    assign bus.Rf_rs1_data = (poison_x0 && bus.Rf_rs1_address == 5'd0) ? 32'hFFFF_FFFF
                                                                       : mem[bus.Rf_rs1_address];

    task automatic tick();
        @(posedge Clk_100MHz);
        #1;
    endtask

    task automatic test_reset();
        bus.WB_wr_en = 0; bus.WB_rd_address = 0; bus.WB_rd_data = 0;
        bus.ID_rs1_address = 5'd9; bus.Pipe_empty = 0; bus.Dbg_halt_req = 0;
        bus.Dbg_req_valid = 0; bus.Dbg_req_write = 0; bus.Dbg_req_address = 0;
        bus.Dbg_req_wdata = 0;
        tick(); tick();
        checks++;
        if ({bus.Stall_req, bus.Halted, bus.Init_done, bus.Rf_wr_en, bus.Dbg_rsp_valid,
             bus.Dbg_req_ready, bus.Dbg_rsp_rdata} !== {1'b1, 5'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values stall=%b halted=%b done=%b wr=%b rsp=%b rdy=%b rdata=%h, need stall=1 others 0",
                     bus.Stall_req, bus.Halted, bus.Init_done, bus.Rf_wr_en,
                     bus.Dbg_rsp_valid, bus.Dbg_req_ready, bus.Dbg_rsp_rdata);
        end
    endtask

    task automatic test_clear(input string tag);
        Reset = 0;
        #1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if ({bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data, bus.Stall_req,
                 bus.Init_done, bus.Dbg_req_ready} !== {1'b1, 5'(i), 32'h0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s_clear cycle %0d: wr=%b addr=%0d data=%h stall=%b done=%b rdy=%b, need wr=1 addr=%0d data=0 stall=1 done=0 rdy=0",
                         tag, i, bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data,
                         bus.Stall_req, bus.Init_done, bus.Dbg_req_ready, i);
            end
            tick();
        end
        checks++;
        if ({bus.Init_done, bus.Stall_req, bus.Rf_wr_en} !== 3'b100) begin
            errors++;
            $display("FAIL %s_init_done done=%b stall=%b wr=%b, need done=1 stall=0 wr=0",
                     tag, bus.Init_done, bus.Stall_req, bus.Rf_wr_en);
        end
    endtask

    task automatic test_wb_run();
        bus.WB_wr_en = 1; bus.WB_rd_address = 5'd5; bus.WB_rd_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data, bus.Rf_rs1_address} !==
            {1'b1, 5'd5, 32'hDEADBEEF, 5'd9}) begin
            errors++;
            $display("FAIL wb_run wr=%b addr=%0d data=%h rs1=%0d, need 1/5/deadbeef/9",
                     bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data, bus.Rf_rs1_address);
        end
        bus.WB_rd_address = 5'd0;
        #1;
        checks++;
        if (bus.Rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL wb_x0 wr=%b, need 0", bus.Rf_wr_en);
        end
    endtask

    task automatic test_halt_wait();
        tick();
        bus.WB_wr_en = 0; bus.Dbg_halt_req = 1; bus.Pipe_empty = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.WB_wr_en = 1; bus.WB_rd_address = 5'(10 + k); bus.WB_rd_data = 32'(100 + k);
            #1;
            checks++;
            if ({bus.Stall_req, bus.Halted, bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data} !==
                {1'b1, 1'b0, 1'b1, 5'(10 + k), 32'(100 + k)}) begin
                errors++;
                $display("FAIL halt_wait_drain %0d stall=%b halted=%b wr=%b addr=%0d data=%0d, need 1/0/1/%0d/%0d",
                         k, bus.Stall_req, bus.Halted, bus.Rf_wr_en, bus.Rf_rd_address,
                         bus.Rf_wr_data, 10 + k, 100 + k);
            end
            tick();
        end
        bus.WB_wr_en = 0; bus.Dbg_halt_req = 0;
        tick();
        checks++;
        if ({bus.Stall_req, bus.Halted} !== 2'b00) begin
            errors++;
            $display("FAIL halt_abort stall=%b halted=%b, need 0/0", bus.Stall_req, bus.Halted);
        end
        bus.Dbg_halt_req = 1;
        tick();
        bus.Pipe_empty = 1;
        tick();
        checks++;
        if ({bus.Stall_req, bus.Halted} !== 2'b11) begin
            errors++;
            $display("FAIL halted_entry stall=%b halted=%b, need 1/1", bus.Stall_req, bus.Halted);
        end
    endtask

    task automatic test_dbg_rw();
        bus.Dbg_req_valid = 1; bus.Dbg_req_write = 1; bus.Dbg_req_address = 5'd7;
        bus.Dbg_req_wdata = 32'h1234;
        #1;
        checks++;
        if ({bus.Dbg_req_ready, bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data} !==
            {1'b1, 1'b1, 5'd7, 32'h1234}) begin
            errors++;
            $display("FAIL dbg_write_port rdy=%b wr=%b addr=%0d data=%h, need 1/1/7/1234",
                     bus.Dbg_req_ready, bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data);
        end
        tick();
        checks++;
        if ({bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL dbg_write_rsp valid=%b rdata=%h, need 1/0", bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata);
        end
        bus.Dbg_req_write = 0;
        #1;
        checks++;
        if ({bus.Rf_rs1_address, bus.Rf_wr_en} !== {5'd7, 1'b0}) begin
            errors++;
            $display("FAIL dbg_read_rs1 rs1=%0d wr=%b, need 7/0", bus.Rf_rs1_address, bus.Rf_wr_en);
        end
        tick();
        checks++;
        if ({bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata} !== {1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL dbg_read_rsp valid=%b rdata=%h, need 1/1234", bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata);
        end
        poison_x0 = 1; bus.Dbg_req_address = 5'd0;
        tick();
        checks++;
        if ({bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL dbg_read_x0 valid=%b rdata=%h, need 1/0", bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata);
        end
        poison_x0 = 0; bus.Dbg_req_write = 1; bus.Dbg_req_wdata = 32'h55;
        #1;
        checks++;
        if ({bus.Dbg_req_ready, bus.Rf_wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL dbg_write_x0 rdy=%b wr=%b, need 1/0", bus.Dbg_req_ready, bus.Rf_wr_en);
        end
        tick();
        bus.Dbg_req_valid = 0;
        checks++;
        if (bus.Dbg_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL dbg_write_x0_ack valid=%b, need 1", bus.Dbg_rsp_valid);
        end
        tick();
        checks++;
        if (bus.Dbg_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_single_pulse valid=%b, need 0", bus.Dbg_rsp_valid);
        end
    endtask

    task automatic test_wb_priority();
        bus.Dbg_req_valid = 1; bus.Dbg_req_write = 1; bus.Dbg_req_address = 5'd9;
        bus.Dbg_req_wdata = 32'hAA; bus.WB_wr_en = 1; bus.WB_rd_address = 5'd4;
        bus.WB_rd_data = 32'h55;
        #1;
        checks++;
        if ({bus.Dbg_req_ready, bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data} !==
            {1'b0, 1'b1, 5'd4, 32'h55}) begin
            errors++;
            $display("FAIL wb_priority rdy=%b wr=%b addr=%0d data=%h, need 0/1/4/55",
                     bus.Dbg_req_ready, bus.Rf_wr_en, bus.Rf_rd_address, bus.Rf_wr_data);
        end
        tick();
        bus.WB_wr_en = 0;
        #1;
        checks++;
        if ({bus.Dbg_rsp_valid, bus.Dbg_req_ready, bus.Rf_rd_address, bus.Rf_wr_data} !==
            {1'b0, 1'b1, 5'd9, 32'hAA}) begin
            errors++;
            $display("FAIL dbg_after_wb rsp=%b rdy=%b addr=%0d data=%h, need 0/1/9/aa",
                     bus.Dbg_rsp_valid, bus.Dbg_req_ready, bus.Rf_rd_address, bus.Rf_wr_data);
        end
        tick();
        bus.Dbg_req_valid = 0;
        checks++;
        if ({bus.Dbg_rsp_valid, mem[4], mem[9]} !== {1'b1, 32'h55, 32'hAA}) begin
            errors++;
            $display("FAIL wb_dbg_writes rsp=%b x4=%h x9=%h, need 1/55/aa", bus.Dbg_rsp_valid, mem[4], mem[9]);
        end
    endtask

    task automatic test_halt_exit();
        bus.Dbg_halt_req = 0; bus.Dbg_req_valid = 1; bus.Dbg_req_write = 0;
        bus.Dbg_req_address = 5'd7;
        #1;
        checks++;
        if ({bus.Dbg_req_ready, bus.Rf_rs1_address} !== {1'b1, 5'd7}) begin
            errors++;
            $display("FAIL exit_accept rdy=%b rs1=%0d, need 1/7", bus.Dbg_req_ready, bus.Rf_rs1_address);
        end
        tick();
        bus.Dbg_req_valid = 0;
        checks++;
        if ({bus.Halted, bus.Stall_req, bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata} !==
            {1'b0, 1'b0, 1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL exit_rsp halted=%b stall=%b rsp=%b rdata=%h, need 0/0/1/1234",
                     bus.Halted, bus.Stall_req, bus.Dbg_rsp_valid, bus.Dbg_rsp_rdata);
        end
    endtask

    task automatic test_reset_inflight();
        bus.Dbg_halt_req = 1; bus.Pipe_empty = 1;
        tick(); tick();
        bus.Dbg_req_valid = 1; bus.Dbg_req_write = 0; bus.Dbg_req_address = 5'd7;
        #1;
        checks++;
        if ({bus.Halted, bus.Dbg_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL rehalt halted=%b rdy=%b, need 1/1", bus.Halted, bus.Dbg_req_ready);
        end
        #2 Reset = 1;
        #1;
        bus.Dbg_req_valid = 0; bus.Dbg_halt_req = 0;
        tick();
        checks++;
        if ({bus.Dbg_rsp_valid, bus.Halted, bus.Stall_req, bus.Rf_wr_en, bus.Init_done} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_inflight rsp=%b halted=%b stall=%b wr=%b done=%b, need 0/0/1/0/0",
                     bus.Dbg_rsp_valid, bus.Halted, bus.Stall_req, bus.Rf_wr_en, bus.Init_done);
        end
        test_clear("restart");
        checks++;
        if (mem[7] !== 32'h0) begin
            errors++;
            $display("FAIL restart_cleared x7=%h, need 0", mem[7]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear("boot");
        test_wb_run();
        test_halt_wait();
        test_dbg_rw();
        test_wb_priority();
        test_halt_exit();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
